// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame serializer: register map,
// frame size and the serializer FSM state encoding.
package max7219_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [3:0] NOOP         = 4'h0;
   localparam logic [3:0] DIGIT0       = 4'h1;
   localparam logic [3:0] DIGIT1       = 4'h2;
   localparam logic [3:0] DIGIT2       = 4'h3;
   localparam logic [3:0] DIGIT3       = 4'h4;
   localparam logic [3:0] DIGIT4       = 4'h5;
   localparam logic [3:0] DIGIT5       = 4'h6;
   localparam logic [3:0] DIGIT6       = 4'h7;
   localparam logic [3:0] DIGIT7       = 4'h8;
   localparam logic [3:0] DECODE_MODE  = 4'h9;
   localparam logic [3:0] INTENSITY    = 4'hA;
   localparam logic [3:0] SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] SHUTDOWN     = 4'hC;
   localparam logic [3:0] DISPLAY_TEST = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

endpackage

// File: rtl/max7219_bit_timer.sv
// SCLK half-period timer: reloads on load, then ticks once every CLK_DIV
// cycles for as long as run is high.
module max7219_bit_timer
   import max7219_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (run) begin
         count <= (count == '0) ? RELOAD : count - CW'(1);
      end
   end

   assign tick = run && (count == '0);

endmodule

// File: rtl/max7219_frame_tx.sv
// Serializes one MAX7219 register write into a 16-bit mode-0 SPI frame
// with LOAD (cs_n) held low across the whole word.
module max7219_frame_tx
   import max7219_pkg::*;
#(
   parameter int CLK_DIV = 25,
   parameter int CS_GAP  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_addr,
   input  logic [7:0] in_data,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic       busy,
   output logic       done
);

   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

   state_t                  state;
   logic [FRAME_BITS-1:0]   shreg;
   logic [3:0]              bit_cnt;
   logic [GW-1:0]           gap_cnt;
   logic                    hold_second;
   logic                    tick;
   logic                    load;
   logic                    run;

   assign load = in_valid && in_ready;
   assign run  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

   max7219_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         cs_n        <= 1'b1;
         sclk        <= 1'b0;
         mosi        <= 1'b0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         hold_second <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  shreg    <= {4'b0000, in_addr, in_data};
                  mosi     <= 1'b0;
                  cs_n     <= 1'b0;
                  bit_cnt  <= 4'd15;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  sclk  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Data moves only on falling edges, so it is settled a full
               // half-period around every rising edge.
               if (tick) begin
                  if (sclk) begin
                     sclk <= 1'b0;
                     if (bit_cnt == 4'd0) begin
                        mosi        <= 1'b0;
                        hold_second <= 1'b0;
                        state       <= ST_HOLD;
                     end else begin
                        mosi    <= shreg[FRAME_BITS-2];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 4'd1;
                     end
                  end else begin
                     sclk <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // LOAD stays low for two half-periods after the last falling
               // edge, giving a 34 half-period frame.
               if (tick) begin
                  if (hold_second) begin
                     cs_n    <= 1'b1;
                     done    <= 1'b1;
                     gap_cnt <= GAP_LOAD;
                     state   <= ST_GAP;
                  end else begin
                     hold_second <= 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_frame_tx.sv
// Scoreboard bench: handshakes push the expected frame word, a monitor
// decodes the SPI pins and pops/compares at every cs_n rise.
module tb_max7219_frame_tx;

   localparam int CD = 2;
   localparam int CG = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [3:0] in_addr;
   logic [7:0] in_data;
   logic       in_ready, sclk, mosi, cs_n, busy, done;

   logic       f_valid;
   logic [3:0] f_addr;
   logic [7:0] f_data;
   logic       f_ready, f_sclk, f_mosi, f_cs_n, f_busy, f_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   max7219_frame_tx #(.CLK_DIV(CD), .CS_GAP(CG)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .sclk(sclk), .mosi(mosi),
      .cs_n(cs_n), .busy(busy), .done(done)
   );

   max7219_frame_tx #(.CLK_DIV(1), .CS_GAP(2)) u_fast (
      .clk(clk), .reset(reset), .in_valid(f_valid), .in_ready(f_ready),
      .in_addr(f_addr), .in_data(f_data), .sclk(f_sclk), .mosi(f_mosi),
      .cs_n(f_cs_n), .busy(f_busy), .done(f_done)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard state
   int   exp_q[$];
   int   hs_cyc[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   frames_seen = 0;
   int   violations = 0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0;
   logic in_frame = 1'b0, gap_active = 1'b0;
   logic [15:0] word;
   int   bits, low, gap;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         exp_q.delete();
         in_frame   = 1'b0;
         gap_active = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(int'(in_addr) * 256 + int'(in_data));
            hs_cyc.push_back(cyc);
         end
         if (!cs_n && prev_cs) begin
            in_frame = 1'b1;
            word = '0;
            bits = 0;
            low  = 0;
         end
         if (in_frame && !cs_n) begin
            low++;
            if (sclk && !prev_sclk) begin
               word = {word[14:0], mosi};
               bits++;
            end
         end
         if (cs_n && !prev_cs && in_frame) begin
            in_frame = 1'b0;
            frames_seen++;
            if (exp_q.size() == 0) check("unexpected_frame", int'(word), -1);
            else check("frame_word", int'(word), exp_q.pop_front());
            check("sclk_rises", bits, 16);
            check("cs_low_cycles", low, 34 * CD);
            check("done_at_cs_rise", int'(done), 1);
            gap_active = 1'b1;
            gap = 0;
         end else if (gap_active) begin
            gap++;
            if (in_ready) begin
               check("cs_rise_to_ready", gap, CG);
               gap_active = 1'b0;
            end else if (gap > 1000) begin
               check("ready_timeout", gap, CG);
               gap_active = 1'b0;
            end
         end
         if (cs_n && prev_cs && (sclk !== prev_sclk)) violations++;
         if (done) begin
            done_cnt++;
            if (prev_done) check("done_width", 2, 1);
         end
      end
      prev_sclk = sclk;
      prev_cs   = cs_n;
      prev_done = done;
   end

   task automatic send(input logic [3:0] a, input logic [7:0] d);
      logic rdy;
      in_addr  = a;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check("send_timeout", 0, 1);
   endtask

   task automatic wait_quiet();
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && in_ready && !busy && !gap_active && !in_frame) return;
      end
      check("quiet_timeout", 0, 1);
   endtask

   initial begin
      int d0, f0, cnt, ps, lowc, tog, n;
      logic [15:0] fw;
      logic pr_s, pr_c, started;
      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      f_valid = 1'b0; f_addr = '0; f_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_cs_n", int'(cs_n), 1);
      check("rst_sclk", int'(sclk), 0);
      check("rst_mosi", int'(mosi), 0);
      reset = 1'b0;

      // CLK_DIV=1 instance: 34-cycle frame, sclk toggling every cycle
      f_addr = 4'hF; f_data = 8'h00; f_valid = 1'b1;
      lowc = 0; tog = 0; fw = '0; pr_s = 1'b0; pr_c = 1'b1; started = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!f_cs_n) begin
            f_valid = 1'b0;
            started = 1'b1;
            lowc++;
            if (f_sclk !== pr_s) tog++;
            if (f_sclk && !pr_s) fw = {fw[14:0], f_mosi};
         end
         if (started && f_cs_n && !pr_c) begin
            check("fast_done", int'(f_done), 1);
            break;
         end
         pr_s = f_sclk;
         pr_c = f_cs_n;
      end
      check("fast_started", int'(started), 1);
      check("fast_cs_low", lowc, 34);
      check("fast_toggles", tog, 32);
      check("fast_word", int'(fw), 16'h0F00);
      f_valid = 1'b0;

      // Single SHUTDOWN write
      d0 = done_cnt;
      send(4'hC, 8'h01);
      wait_quiet();
      check("single_done_count", done_cnt - d0, 1);

      // Back-to-back with in_valid held: period 34*CD+CG+1
      send(4'h1, 8'hFF);
      send(4'h8, 8'hA5);
      wait_quiet();
      check("b2b_period", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 34 * CD + CG + 1);

      // Inputs scrambled mid-frame must not alter the word or add frames
      f0 = frames_seen;
      send(4'($urandom), 8'($urandom));
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (in_ready) break;
         in_valid = 1'($urandom);
         in_addr  = 4'($urandom);
         in_data  = 8'($urandom);
      end
      in_valid = 1'b0;
      wait_quiet();
      check("midframe_frames", frames_seen - f0, 1);

      // Reset at the 7th sclk rising edge
      send(4'h3, 8'h5A);
      cnt = 0; ps = 0;
      for (int i = 0; i < 500 && cnt < 7; i++) begin
         @(posedge clk);
         #1;
         if (sclk && ps == 0) cnt++;
         ps = int'(sclk);
      end
      check("reach_7th_rise", cnt, 7);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_cs_n", int'(cs_n), 1);
      check("abort_sclk", int'(sclk), 0);
      check("abort_mosi", int'(mosi), 0);
      check("abort_in_ready", int'(in_ready), 1);
      f0 = frames_seen;
      send(4'hA, 8'h3C);
      wait_quiet();
      check("post_abort_frames", frames_seen - f0, 1);

      // Eight-digit pattern, back-to-back
      d0 = done_cnt;
      for (int i = 1; i <= 8; i++) send(4'(i), 8'hFF);
      wait_quiet();
      check("digits_done_count", done_cnt - d0, 8);

      // Randomized traffic with random idle spacing
      f0 = frames_seen;
      n = 10;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         send(4'($urandom), 8'($urandom));
      end
      wait_quiet();
      check("random_frames", frames_seen - f0, n);

      check("sclk_edge_while_cs_high", violations, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
